uart_rx: RTL and testbench

Asynchronous serial receiver, 8N1, LSB first: counterpart to the team's UART transmitter on the same link. Synchronises the `rx` line, detects and qualifies start bits, samples each bit at its midpoint and presents each received byte with a single-cycle `valid` strobe. It sits between the board-level RX pin and the byte-consuming logic (command parser / FIFO), which must accept `data` on the `valid` cycle.

---
 rtl/uart_rx.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 serial receiver, LSB first: synchronises rx, qualifies the start bit, samples mid-bit.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err strobe alongside valid.
module uart_rx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, rx_s_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sh_q, sh_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic          par_q, par_d;
    logic          parity_err_q, parity_err_d;
`endif

    logic at_mid;
    logic at_half;

    assign at_mid  = (cnt_q == LAST);
    assign at_half = (cnt_q == HALF_M1);

    // Synchroniser resets to the idle-high level so reset never fakes a start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            rx_s_q  <= sync1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            sh_q         <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            sh_q         <= sh_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (at_half) state_d = rx_s_q ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (at_mid && idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
            S_PARITY: begin
                if (at_mid) state_d = S_STOP;
            end
            S_STOP: begin
                if (at_mid) state_d = rx_s_q ? S_IDLE : S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
                // A held-low line (break) must not be decoded as a stream of zero bytes
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        sh_d         = sh_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
            end
            S_START: begin
                if (at_half) begin
                    cnt_d = '0;
                    idx_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (at_mid) begin
                    cnt_d = '0;
                    sh_d  = {rx_s_q, sh_q[7:1]};
                    idx_d = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_PARITY: begin
                if (at_mid) begin
                    cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                    par_d = rx_s_q;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (at_mid) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        data_d       = sh_q;
                        valid_d      = 1'b1;
`ifdef UART_RX_PARITY_EN
                        parity_err_d = (^sh_q) ^ par_q;
`endif
                    end else begin
                        frame_err_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_HIGH: begin
                cnt_d = '0;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        busy       = (state_q != S_IDLE);
        data       = data_q;
        valid      = valid_q;
        frame_err  = frame_err_q;
`ifdef UART_RX_PARITY_EN
        parity_err = parity_err_q;
`endif
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: randomized and directed frames checked against an event-level reference model.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    // Start-edge drive cycle to strobe cycle: 2 sync flops, half bit, data/parity/stop bits, output register
    localparam int LAT = 2 + HALF + (9 + PBITS) * CPB + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] d;
        int         c;
        bit         pe;
    } ev_t;

    ev_t        got[$];
    ev_t        exp_q[$];
    ev_t        mev;
    int         both_cnt;
    bit         busy_seen;
    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] model_data  = 8'h00;

    always @(negedge clk) begin
        if (!rst) begin
            if (valid && frame_err) both_cnt++;
            if (busy) busy_seen = 1'b1;
            if (valid || frame_err) begin
                mev.is_err = frame_err && !valid;
                mev.d      = data;
                mev.c      = cyc;
`ifdef UART_RX_PARITY_EN
                mev.pe     = parity_err;
`else
                mev.pe     = 1'b0;
`endif
                got.push_back(mev);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        tick(CPB);
    endtask

    task automatic idle_cycles(input int n);
        rx = 1'b1;
        tick(n);
    endtask

    task automatic clear_events();
        got.delete();
        exp_q.delete();
        both_cnt  = 0;
        busy_seen = 1'b0;
    endtask

    // Reference model: each frame yields exactly one event, LAT cycles after its start edge
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
        ev_t e;
        e.is_err = !stop_bit;
        e.c      = cyc + LAT;
        e.pe     = stop_bit ? ((^b) ^ par_bit) : 1'b0;
        if (stop_bit) model_data = b;
        e.d      = model_data;
        exp_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_bit);
`endif
        drive_bit(stop_bit);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        tick(3);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", valid); end
        vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        vectors++; if (data !== 8'h00) begin miscompares++; $display("FAIL reset_data got %h want 00", data); end
`ifdef UART_RX_PARITY_EN
        vectors++; if (parity_err !== 1'b0) begin miscompares++; $display("FAIL reset_parity_err got %b want 0", parity_err); end
`endif
        rst = 1'b0;
        clear_events();
        idle_cycles(10 * CPB);
        vectors++; if (got.size() != 0) begin miscompares++; $display("FAIL idle_events got %0d want 0", got.size()); end
        vectors++; if (busy_seen !== 1'b0) begin miscompares++; $display("FAIL idle_busy got %b want 0", busy_seen); end
        vectors++; if (data !== 8'h00) begin miscompares++; $display("FAIL idle_data got %h want 00", data); end
    endtask

    task automatic test_back_to_back();
        clear_events();
        send_frame(8'hA5, 1'b1, ^8'hA5);
        send_frame(8'h3C, 1'b1, ^8'h3C);
        idle_cycles(2 * CPB);
        vectors++; if (got.size() != 2) begin miscompares++; $display("FAIL b2b_count got %0d want 2", got.size()); end
        for (int i = 0; i < 2 && i < got.size(); i++) begin
            vectors++; if (got[i].is_err != 1'b0) begin miscompares++; $display("FAIL b2b_kind[%0d] got frame_err want valid", i); end
            vectors++; if (got[i].d !== exp_q[i].d) begin miscompares++; $display("FAIL b2b_data[%0d] got %h want %h", i, got[i].d, exp_q[i].d); end
            vectors++; if (got[i].c < exp_q[i].c - 1 || got[i].c > exp_q[i].c + 1) begin
                miscompares++; $display("FAIL b2b_time[%0d] got %0d want %0d+-1", i, got[i].c, exp_q[i].c);
            end
        end
        vectors++; if (both_cnt != 0) begin miscompares++; $display("FAIL b2b_both got %0d want 0", both_cnt); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_busy_end got %b want 0", busy); end
    endtask

    task automatic test_glitch();
        clear_events();
        rx = 1'b0;
        tick(3);
        idle_cycles(2 * CPB);
        vectors++; if (busy_seen !== 1'b1) begin miscompares++; $display("FAIL glitch_busy_pulse got %b want 1", busy_seen); end
        vectors++; if (got.size() != 0) begin miscompares++; $display("FAIL glitch_events got %0d want 0", got.size()); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL glitch_busy_end got %b want 0", busy); end
    endtask

    task automatic test_frame_err();
        logic [7:0] old;
        clear_events();
        old = model_data;
        send_frame(8'h55, 1'b0, ^8'h55);
        rx = 1'b0;
        tick(20 * CPB);
        idle_cycles(2 * CPB);
        vectors++; if (data !== old) begin miscompares++; $display("FAIL break_data got %h want %h", data, old); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL break_busy got %b want 0", busy); end
        send_frame(8'h81, 1'b1, ^8'h81);
        idle_cycles(2 * CPB);
        vectors++; if (got.size() != 2) begin miscompares++; $display("FAIL ferr_count got %0d want 2", got.size()); end
        for (int i = 0; i < 2 && i < got.size(); i++) begin
            vectors++; if (got[i].is_err != exp_q[i].is_err) begin miscompares++; $display("FAIL ferr_kind[%0d] got %b want %b", i, got[i].is_err, exp_q[i].is_err); end
            vectors++; if (got[i].d !== exp_q[i].d) begin miscompares++; $display("FAIL ferr_data[%0d] got %h want %h", i, got[i].d, exp_q[i].d); end
            vectors++; if (got[i].c < exp_q[i].c - 1 || got[i].c > exp_q[i].c + 1) begin
                miscompares++; $display("FAIL ferr_time[%0d] got %0d want %0d+-1", i, got[i].c, exp_q[i].c);
            end
`ifdef UART_RX_PARITY_EN
            vectors++; if (got[i].pe != exp_q[i].pe) begin miscompares++; $display("FAIL ferr_perr[%0d] got %b want %b", i, got[i].pe, exp_q[i].pe); end
`endif
        end
        vectors++; if (both_cnt != 0) begin miscompares++; $display("FAIL ferr_both got %0d want 0", both_cnt); end
    endtask

    task automatic test_reset_abort();
        clear_events();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rx = 1'b1;
        tick(HALF);
        rst = 1'b1;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b want 0", busy); end
        tick(2);
        rst = 1'b0;
        model_data = 8'h00;
        idle_cycles(3 * CPB);
        vectors++; if (got.size() != 0) begin miscompares++; $display("FAIL abort_events got %0d want 0", got.size()); end
        vectors++; if (data !== 8'h00) begin miscompares++; $display("FAIL abort_data got %h want 00", data); end
        send_frame(8'h0F, 1'b1, ^8'h0F);
        idle_cycles(2 * CPB);
        vectors++; if (got.size() != 1) begin miscompares++; $display("FAIL abort_resume_count got %0d want 1", got.size()); end
        if (got.size() >= 1) begin
            vectors++; if (got[0].is_err || got[0].d !== 8'h0F) begin
                miscompares++; $display("FAIL abort_resume_data got err=%b %h want valid 0f", got[0].is_err, got[0].d);
            end
            vectors++; if (got[0].c < exp_q[0].c - 1 || got[0].c > exp_q[0].c + 1) begin
                miscompares++; $display("FAIL abort_resume_time got %0d want %0d+-1", got[0].c, exp_q[0].c);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       stop_bit;
        logic       par_bit;
        clear_events();
        for (int n = 0; n < 12; n++) begin
            b        = 8'($urandom);
            stop_bit = ($urandom_range(0, 4) != 0);
            par_bit  = 1'($urandom_range(0, 1));
            send_frame(b, stop_bit, par_bit);
            if (!stop_bit) idle_cycles(2 * CPB);
            else           idle_cycles($urandom_range(0, 20));
        end
        idle_cycles(2 * CPB);
        vectors++; if (got.size() != exp_q.size()) begin miscompares++; $display("FAIL rand_count got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            vectors++; if (got[i].is_err != exp_q[i].is_err) begin miscompares++; $display("FAIL rand_kind[%0d] got %b want %b", i, got[i].is_err, exp_q[i].is_err); end
            vectors++; if (got[i].d !== exp_q[i].d) begin miscompares++; $display("FAIL rand_data[%0d] got %h want %h", i, got[i].d, exp_q[i].d); end
            vectors++; if (got[i].c < exp_q[i].c - 1 || got[i].c > exp_q[i].c + 1) begin
                miscompares++; $display("FAIL rand_time[%0d] got %0d want %0d+-1", i, got[i].c, exp_q[i].c);
            end
`ifdef UART_RX_PARITY_EN
            vectors++; if (got[i].pe != exp_q[i].pe) begin miscompares++; $display("FAIL rand_perr[%0d] got %b want %b", i, got[i].pe, exp_q[i].pe); end
`endif
        end
        vectors++; if (both_cnt != 0) begin miscompares++; $display("FAIL rand_both got %0d want 0", both_cnt); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        clear_events();
        send_frame(8'h07, 1'b1, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1);
        idle_cycles(2 * CPB);
        vectors++; if (got.size() != 2) begin miscompares++; $display("FAIL par_count got %0d want 2", got.size()); end
        if (got.size() >= 2) begin
            vectors++; if (got[0].is_err || got[0].d !== 8'h07) begin miscompares++; $display("FAIL par_bad_data got err=%b %h want valid 07", got[0].is_err, got[0].d); end
            vectors++; if (got[0].pe !== 1'b1) begin miscompares++; $display("FAIL par_bad_flag got %b want 1", got[0].pe); end
            vectors++; if (got[1].pe !== 1'b0) begin miscompares++; $display("FAIL par_good_flag got %b want 0", got[1].pe); end
            vectors++; if (got[1].c < exp_q[1].c - 1 || got[1].c > exp_q[1].c + 1) begin
                miscompares++; $display("FAIL par_time got %0d want %0d+-1", got[1].c, exp_q[1].c);
            end
        end
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_abort();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
